// File: rtl/mem_arbiter.sv
// Two-master (fetch, data) to one-slave memory arbiter. Data has priority;
// a bounded-wait counter forces a fetch grant after IWAIT_MAX lost contests.
module mem_arbiter #(
  parameter int IWAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [3:0] WMAX = 4'(IWAIT_MAX);

  state_t     state, state_next;
  logic [3:0] wcnt;
  logic       done, decide, cand_i, cand_d, grant_i, grant_d;

  // The master completing this cycle is never a candidate, so a completion
  // with the other master waiting always hands over without a bubble.
  always_comb begin
    done       = (state != IDLE) && mem_ready;
    decide     = (state == IDLE) || done;
    cand_i     = imem_valid && (state != BUSY_I);
    cand_d     = dmem_valid && (state != BUSY_D);
    grant_i    = decide && cand_i && (!cand_d || (wcnt >= WMAX));
    grant_d    = decide && cand_d && !grant_i;
    state_next = state;
    if (grant_i)      state_next = BUSY_I;
    else if (grant_d) state_next = BUSY_D;
    else if (done)    state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (grant_i) begin
      wcnt <= '0;
    end else if (grant_d && imem_valid && (wcnt < WMAX)) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  // Registered downstream request; held untouched while a transfer is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant_i) begin
      mem_valid <= 1'b1;
      mem_instr <= 1'b1;
      mem_addr  <= imem_addr;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant_d) begin
      mem_valid <= 1'b1;
      mem_instr <= dmem_instr;
      mem_addr  <= dmem_addr;
      mem_wdata <= dmem_wdata;
      mem_wstrb <= dmem_wstrb;
    end else if (decide) begin
      mem_valid <= 1'b0;
    end
  end

  assign imem_ready = (state == BUSY_I) && mem_ready;
  assign dmem_ready = (state == BUSY_D) && mem_ready;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transfers plus hand-written
// contention, starvation, reset and stray-ready sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_instr, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.IWAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        di;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    int          lat;
    logic [31:0] rd;
    logic        e_fetch;
    logic        e_instr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  grant_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    grant_t g;
    g.instr = 1'b1; g.addr = a; g.wdata = '0; g.wstrb = '0;
    exp_q.push_back(g);
  endtask

  task automatic push_data(input logic i, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] s);
    grant_t g;
    g.instr = i; g.addr = a; g.wdata = w; g.wstrb = s;
    exp_q.push_back(g);
  endtask

  // Called when a new request has just appeared on the mem_* outputs.
  task automatic got_grant(input string name);
    grant_t g;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected grant addr %h, scoreboard empty", name, mem_addr);
    end else begin
      g = exp_q.pop_front();
      if (mem_valid !== 1'b1 || mem_instr !== g.instr || mem_addr !== g.addr ||
          mem_wdata !== g.wdata || mem_wstrb !== g.wstrb) begin
        bad++;
        $display("FAIL %s: got v=%b i=%b a=%h w=%h s=%h want v=1 i=%b a=%h w=%h s=%h",
                 name, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                 g.instr, g.addr, g.wdata, g.wstrb);
      end
    end
  endtask

  task automatic idle_inputs();
    imem_valid = 0; imem_addr = '0;
    dmem_valid = 0; dmem_instr = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 2, 32'h13, 1, 1, 32'h100, 0, 0};
    vecs[1] = '{0, 0, 1, 0, 32'h2000, 32'h55, 4'h0, 1, 32'hCAFEF00D, 0, 0, 32'h2000, 32'h55, 4'h0};
    vecs[2] = '{0, 0, 1, 0, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, 0, 32'h1000, 32'hDEADBEEF, 4'hF};
    vecs[3] = '{0, 0, 1, 0, 32'h1001, 32'h0000AB00, 4'h2, 5, 32'h1, 0, 0, 32'h1001, 32'h0000AB00, 4'h2};
    vecs[4] = '{0, 0, 1, 1, 32'h3000, 32'h0, 4'h0, 3, 32'h12345678, 0, 1, 32'h3000, 32'h0, 4'h0};
    vecs[5] = '{1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFC, 0, 0};

    idle_inputs();
    rst = 1;
    #12;
    chk("rst_mem_valid", {31'd0, mem_valid}, 0);
    chk("rst_mem_fields", mem_addr | mem_wdata | {28'd0, mem_wstrb} | {31'd0, mem_instr}, 0);
    chk("rst_readies", {30'd0, imem_ready, dmem_ready}, 0);
    chk("rst_wcnt", {28'd0, dut.wcnt}, 0);
    tick();
    rst = 0;
    tick();

    // Table of single, uncontended transfers from IDLE.
    for (int n = 0; n < 6; n++) begin
      imem_valid = vecs[n].iv; imem_addr = vecs[n].ia;
      dmem_valid = vecs[n].dv; dmem_instr = vecs[n].di; dmem_addr = vecs[n].da;
      dmem_wdata = vecs[n].dw; dmem_wstrb = vecs[n].ds;
      push_data(vecs[n].e_instr, vecs[n].e_addr, vecs[n].e_wdata, vecs[n].e_wstrb);
      #1;
      chk($sformatf("v%0d_pre_valid", n), {31'd0, mem_valid}, 0);
      tick(); #1;
      got_grant($sformatf("v%0d_grant", n));
      for (int w = 0; w < vecs[n].lat; w++) begin
        chk($sformatf("v%0d_wait%0d_ready", n, w), {30'd0, imem_ready, dmem_ready}, 0);
        tick();
        // Upstream changes after the grant must not reach the held request.
        imem_addr = ~vecs[n].ia; dmem_addr = ~vecs[n].da; dmem_wstrb = ~vecs[n].ds;
        #1;
        chk($sformatf("v%0d_hold%0d_addr", n, w), mem_addr, vecs[n].e_addr);
        chk($sformatf("v%0d_hold%0d_wstrb", n, w), {28'd0, mem_wstrb}, {28'd0, vecs[n].e_wstrb});
      end
      mem_ready = 1; mem_rdata = vecs[n].rd;
      #1;
      chk($sformatf("v%0d_readies", n), {30'd0, imem_ready, dmem_ready},
          {30'd0, vecs[n].e_fetch, !vecs[n].e_fetch});
      chk($sformatf("v%0d_rdata", n), vecs[n].e_fetch ? imem_rdata : dmem_rdata, vecs[n].rd);
      tick();
      idle_inputs();
      #1;
      chk($sformatf("v%0d_post_valid", n), {31'd0, mem_valid}, 0);
      chk($sformatf("v%0d_post_state", n), 32'(dut.state), 0);
    end

    // Simultaneous requests: data first, fetch follows with no bubble.
    imem_valid = 1; imem_addr = 32'h200;
    dmem_valid = 1; dmem_addr = 32'h1000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
    push_data(0, 32'h1000, 32'hDEADBEEF, 4'hF);
    push_fetch(32'h200);
    tick(); #1;
    got_grant("sim_data_first");
    chk("sim_wcnt1", {28'd0, dut.wcnt}, 1);
    tick();
    mem_ready = 1; mem_rdata = 32'h77;
    #1;
    chk("sim_d_readies", {30'd0, imem_ready, dmem_ready}, 2'b01);
    tick();
    dmem_valid = 0; mem_ready = 0;
    #1;
    got_grant("sim_fetch_no_bubble");
    chk("sim_wcnt0", {28'd0, dut.wcnt}, 0);
    mem_ready = 1; mem_rdata = 32'h88;
    #1;
    chk("sim_i_readies", {30'd0, imem_ready, dmem_ready}, 2'b10);
    chk("sim_i_rdata", imem_rdata, 32'h88);
    tick();
    idle_inputs();
    #1;
    chk("sim_idle", {31'd0, mem_valid}, 0);

    // Starvation: fetch loses four contests, then is forced to win.
    for (int k = 0; k < 4; k++) begin
      imem_valid = 1; imem_addr = 32'h300;
      dmem_valid = 1; dmem_addr = 32'h4000 + k; dmem_wstrb = 0; dmem_wdata = 0;
      push_data(0, 32'h4000 + k, 0, 0);
      tick(); #1;
      got_grant($sformatf("stv_d%0d", k));
      chk($sformatf("stv_wcnt%0d", k), {28'd0, dut.wcnt}, k + 1);
      mem_ready = 1; imem_valid = 0;
      #1;
      chk($sformatf("stv_d%0d_ready", k), {30'd0, imem_ready, dmem_ready}, 2'b01);
      tick();
      mem_ready = 0; dmem_valid = 0;
      #1;
      chk($sformatf("stv_idle%0d", k), {31'd0, mem_valid}, 0);
    end
    imem_valid = 1; imem_addr = 32'h300;
    dmem_valid = 1; dmem_addr = 32'h5000;
    push_fetch(32'h300);
    push_data(0, 32'h5000, 0, 0);
    tick(); #1;
    got_grant("stv_forced_fetch");
    chk("stv_wcnt_clr", {28'd0, dut.wcnt}, 0);
    mem_ready = 1;
    #1;
    chk("stv_i_ready", {30'd0, imem_ready, dmem_ready}, 2'b10);
    tick();
    imem_valid = 0; mem_ready = 0;
    #1;
    got_grant("stv_data_again");
    mem_ready = 1;
    #1;
    chk("stv_d_ready", {30'd0, imem_ready, dmem_ready}, 2'b01);
    tick();
    idle_inputs();
    #1;
    chk("stv_idle_end", {31'd0, mem_valid}, 0);

    // Reset during BUSY_D abandons the transfer.
    dmem_valid = 1; dmem_addr = 32'h6000; dmem_wdata = 32'hAA; dmem_wstrb = 4'h1;
    push_data(0, 32'h6000, 32'hAA, 4'h1);
    tick(); #1;
    got_grant("rst_mid_grant");
    rst = 1;
    #1;
    chk("rst_mid_valid", {31'd0, mem_valid}, 0);
    chk("rst_mid_fields", mem_addr | mem_wdata | {28'd0, mem_wstrb} | {31'd0, mem_instr}, 0);
    tick();
    dmem_valid = 0; rst = 0;
    tick();
    mem_ready = 1;
    #1;
    chk("rst_late_ready", {30'd0, imem_ready, dmem_ready}, 0);
    tick();
    mem_ready = 0;
    #1;
    chk("rst_late_state", 32'(dut.state), 0);
    chk("rst_late_valid", {31'd0, mem_valid}, 0);

    // Stray mem_ready while IDLE.
    mem_ready = 1;
    #1;
    chk("stray_readies", {30'd0, imem_ready, dmem_ready}, 0);
    tick();
    mem_ready = 0;
    #1;
    chk("stray_state", 32'(dut.state), 0);
    chk("stray_valid", {31'd0, mem_valid}, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule
